featuremap_conv2d_0_sched: RTL
==============================

FEATUREMAP_CONV2D_0_SCHED -- requirements
Module: featuremap_conv2d_0_sched

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: sample word width.
REQ-002 SHALL have parameter NFILT, default 8: number of filter cores served.
REQ-003 SHALL have parameter NUM_IN_WORDS, default 1024: input words per frame.
REQ-004 SHALL have parameter NUM_OUT_PIX, default 900: output pixels per frame, NFILT words each.
REQ-005 SHALL have parameter CNT_W, default 16: counter width.
REQ-006 SHALL have port clock, input, 1 bit: single clock, all logic rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: frame start pulse.
REQ-009 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-011 SHALL have port src_rdata, input, DWIDTH*3 bits: show-ahead source FIFO head.
REQ-012 SHALL have ports src_empty (input, 1 bit) and src_rdreq (output, 1 bit): source FIFO handshake.
REQ-013 SHALL have port flt_rdata, output, DWIDTH*3 bits: input word broadcast to all filters.
REQ-014 SHALL have ports flt_empty (output, NFILT bits) and flt_rdreq (input, NFILT bits): per-filter read handshake.
REQ-015 SHALL have ports flt_wdata (input, NFILT*DWIDTH bits), flt_wrreq (input, NFILT bits) and flt_full (output, NFILT bits): per-filter write side; filter i uses slice i.
REQ-016 SHALL have ports dst_wdata (output, DWIDTH bits), dst_wrreq (output, 1 bit) and dst_full (input, 1 bit): merged output FIFO.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when out_cnt reaches NUM_OUT_PIX; DONE -> IDLE after one cycle.
REQ-018 SHALL ignore start outside IDLE and assert done only in DONE.
REQ-019 SHALL drive flt_rdata = src_rdata combinationally, with zero added latency.
REQ-020 SHALL assert flt_empty[i] when src_empty, or taken[i], or in_cnt == NUM_IN_WORDS, or state != RUN.
REQ-021 SHALL ignore flt_rdreq[i] while flt_empty[i] is high.
REQ-022 SHALL set taken[i] on an accepted flt_rdreq[i].
REQ-023 SHALL assert src_rdreq in the cycle where (taken | accepted flt_rdreq) is all ones, then clear taken and increment in_cnt in that cycle; when the last filters read simultaneously, the pop occurs in that same cycle.
REQ-024 SHALL give each filter a 2-entry FIFO buffer, with flt_full[i] high when it holds 2 entries and flt_wrreq[i] ignored while full.
REQ-025 SHALL allow a buffer to write and read in the same cycle, keeping its occupancy unchanged.
REQ-026 SHALL keep a channel pointer ptr, 0..NFILT-1, with dst_wrreq = RUN and buffer[ptr] non-empty and !dst_full, and dst_wdata = buffer[ptr] head.
REQ-027 SHALL, on each dst write, pop buffer[ptr] and advance ptr; on wrap NFILT-1 -> 0, increment out_cnt.
REQ-028 SHALL deliver a filter word written at cycle t to dst no earlier than t+1.
REQ-029 SHALL leave ptr stalled on an empty buffer (strict channel order, no skipping) and hold all state while dst_full is high.
REQ-030 SHALL clear in_cnt, out_cnt and ptr on IDLE -> RUN.
REQ-031 SHALL tolerate words left in buffers at DONE (protocol error) without clearing them; verification flags this case.

Reset
REQ-032 SHALL, on reset low, immediately set state IDLE; busy, done, src_rdreq, dst_wrreq = 0; flt_empty = all ones; flt_full = 0; taken, counters and ptr = 0; buffers empty.
REQ-033 SHALL discard buffered data when reset asserts mid-frame, with no dst write until a new start.
REQ-034 SHALL deassert reset synchronously to clock at the integration level, not inside this block.

Structure
REQ-035 SHALL take the FSM state enum, NFILT, DWIDTH, NUM_IN_WORDS, NUM_OUT_PIX and CNT_W defaults from shared package featuremap_conv2d_0_pkg.
REQ-036 SHALL implement the 2-entry buffer as sub-module featuremap_conv2d_0_out_skid (DWIDTH wide), instantiated NFILT times via generate.

Verification
REQ-037 SHALL cover all filters reading the same word in one cycle: src_rdreq pulses exactly once in that cycle, and in_cnt goes 0 -> 1.
REQ-038 SHALL cover filters 0..7 reading in 8 consecutive cycles: src_rdreq is high only in cycle 8, and filter 3 sees flt_empty[3] = 1 from cycle 5 to cycle 8.
REQ-039 SHALL cover filter 5 writing 0xA5 while the other filters write their index: dst receives 0,1,2,3,4,0xA5,6,7 in order, and out_cnt = 1.
REQ-040 SHALL cover dst_full held high 10 cycles with all filters writing 3 words: flt_full = 0xFF after 2 words, then no loss and correct order after release.
REQ-041 SHALL cover a frame with NUM_IN_WORDS = 4 and NUM_OUT_PIX = 2: done pulses once after the 16th dst word, and busy falls the next cycle.
REQ-042 SHALL cover reset asserted mid-frame with 3 words buffered: outputs reach reset values asynchronously, and no dst_wrreq occurs before the next start.

Source files
------------

// File: rtl/featuremap_conv2d_0_pkg.sv
// Shared defaults and FSM state type for the conv2d_0 feature-map scheduler.
// Imported by the scheduler top and its per-filter output buffer.
package featuremap_conv2d_0_pkg;

    localparam int FM_DWIDTH       = 32;
    localparam int FM_NFILT        = 8;
    localparam int FM_NUM_IN_WORDS = 1024;
    localparam int FM_NUM_OUT_PIX  = 900;
    localparam int FM_CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/featuremap_conv2d_0_out_skid.sv
// Two-entry FIFO holding one filter's output words until the merger takes them.
// Ports: wr_data/wr_en/full (filter side), rd_data/rd_en/empty (merger side).
module featuremap_conv2d_0_out_skid
    import featuremap_conv2d_0_pkg::*;
#(
    parameter int DWIDTH = FM_DWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              empty
);

    logic [DWIDTH-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_ok} - {1'b0, rd_ok};
        end
    end

endmodule

// File: rtl/featuremap_conv2d_0_sched.sv
// Frame scheduler: broadcasts source words to NFILT filters, merges outputs.
// Ports: start/busy/done, src_* FIFO, flt_* per-filter, dst_* merged FIFO.
module featuremap_conv2d_0_sched
    import featuremap_conv2d_0_pkg::*;
#(
    parameter int DWIDTH       = FM_DWIDTH,
    parameter int NFILT        = FM_NFILT,
    parameter int NUM_IN_WORDS = FM_NUM_IN_WORDS,
    parameter int NUM_OUT_PIX  = FM_NUM_OUT_PIX,
    parameter int CNT_W        = FM_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [DWIDTH*3-1:0]     src_rdata,
    input  logic                    src_empty,
    output logic                    src_rdreq,
    output logic [DWIDTH*3-1:0]     flt_rdata,
    output logic [NFILT-1:0]        flt_empty,
    input  logic [NFILT-1:0]        flt_rdreq,
    input  logic [NFILT*DWIDTH-1:0] flt_wdata,
    input  logic [NFILT-1:0]        flt_wrreq,
    output logic [NFILT-1:0]        flt_full,
    output logic [DWIDTH-1:0]       dst_wdata,
    output logic                    dst_wrreq,
    input  logic                    dst_full
);

    localparam int PTR_W = (NFILT > 1) ? $clog2(NFILT) : 1;
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(NUM_IN_WORDS);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(NUM_OUT_PIX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NFILT - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    sched_state_t      state;
    logic [NFILT-1:0]  taken;
    logic [NFILT-1:0]  rd_acc;
    logic [NFILT-1:0]  got;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [PTR_W-1:0]  ptr;
    logic              run;
    logic              in_open;
    logic              pop_src;
    logic              wrap;
    logic              frame_end;
    logic [NFILT-1:0]  buf_empty;
    logic [NFILT-1:0]  buf_rd;
    logic [DWIDTH-1:0] buf_head [NFILT];

    assign run     = (state == ST_RUN);
    // A source word is offered only while a frame runs and input remains.
    assign in_open = run & ~src_empty & (in_cnt != IN_LAST);

    assign flt_rdata = src_rdata;
    assign flt_empty = {NFILT{~in_open}} | taken;
    assign rd_acc    = flt_rdreq & ~flt_empty;
    assign got       = taken | rd_acc;

    // Pop as soon as the last outstanding filter reads, same cycle.
    assign pop_src   = in_open & (&got);
    assign src_rdreq = pop_src;

    // Strict round-robin drain: ptr waits on an empty channel.
    assign dst_wrreq = run & ~buf_empty[ptr] & ~dst_full;
    assign dst_wdata = buf_head[ptr];
    assign wrap      = dst_wrreq & (ptr == PTR_LAST);
    assign frame_end = (out_cnt == OUT_LAST)
                     | (wrap & ((out_cnt + CNT_ONE) == OUT_LAST));

    for (genvar i = 0; i < NFILT; i++) begin : g_buf
        assign buf_rd[i] = dst_wrreq & (ptr == PTR_W'(i));

        featuremap_conv2d_0_out_skid #(
            .DWIDTH(DWIDTH)
        ) u_skid (
            .clock   (clock),
            .reset   (reset),
            .wr_data (flt_wdata[i*DWIDTH +: DWIDTH]),
            .wr_en   (flt_wrreq[i]),
            .full    (flt_full[i]),
            .rd_en   (buf_rd[i]),
            .rd_data (buf_head[i]),
            .empty   (buf_empty[i])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            taken   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            ptr     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        taken   <= '0;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        ptr     <= '0;
                    end
                end
                ST_RUN: begin
                    if (pop_src) begin
                        taken  <= '0;
                        in_cnt <= in_cnt + CNT_ONE;
                    end else begin
                        taken <= got;
                    end
                    if (dst_wrreq) begin
                        ptr <= wrap ? '0 : ptr + PTR_ONE;
                        if (wrap) begin
                            out_cnt <= out_cnt + CNT_ONE;
                        end
                    end
                    if (frame_end) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
